// File: rtl/sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// IR field positions, control-flow opcodes and datapath flag indices.
package sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_NEXT,
    S_PAUSE,
    S_HALT
  } state_t;

  localparam int OPER_MSB  = 31;
  localparam int OPER_LSB  = 27;
  localparam int RDST_MSB  = 26;
  localparam int RDST_LSB  = 22;
  localparam int RSRC1_MSB = 21;
  localparam int RSRC1_LSB = 17;
  localparam int IMM_BIT   = 16;
  localparam int RSRC2_MSB = 15;
  localparam int RSRC2_LSB = 11;
  localparam int ISRC_MSB  = 15;
  localparam int ISRC_LSB  = 0;

  localparam logic [4:0] OP_JUMP     = 5'd15;
  localparam logic [4:0] OP_JCARRY   = 5'd16;
  localparam logic [4:0] OP_JNOCARRY = 5'd17;
  localparam logic [4:0] OP_JSIGN    = 5'd18;
  localparam logic [4:0] OP_JNOSIGN  = 5'd19;
  localparam logic [4:0] OP_JZERO    = 5'd20;
  localparam logic [4:0] OP_JNOZERO  = 5'd21;
  localparam logic [4:0] OP_JOVF     = 5'd22;
  localparam logic [4:0] OP_JNOOVF   = 5'd23;
  localparam logic [4:0] OP_HALT     = 5'd27;

  // flags bus is {sign, zero, overflow, carry}
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_SIGN  = 3;

endpackage

// File: rtl/jump_resolve.sv
// Combinational jump classifier: flags whether an opcode is a jump and
// whether its condition holds for the given datapath flags.
module jump_resolve
  import sequencer_pkg::*;
(
  input  logic [4:0] oper_type,
  input  logic [3:0] flags,
  output logic       is_jump,
  output logic       taken
);

  always_comb begin
    is_jump = 1'b1;
    taken   = 1'b0;
    unique case (oper_type)
      OP_JUMP:     taken = 1'b1;
      OP_JCARRY:   taken =  flags[FLAG_CARRY];
      OP_JNOCARRY: taken = ~flags[FLAG_CARRY];
      OP_JSIGN:    taken =  flags[FLAG_SIGN];
      OP_JNOSIGN:  taken = ~flags[FLAG_SIGN];
      OP_JZERO:    taken =  flags[FLAG_ZERO];
      OP_JNOZERO:  taken = ~flags[FLAG_ZERO];
      OP_JOVF:     taken =  flags[FLAG_OVF];
      OP_JNOOVF:   taken = ~flags[FLAG_OVF];
      default:     is_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns the PC, fetches from
// instruction memory, drives ir to the datapath and strobes commit.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   S_IDLE   | out of reset, waiting for start
//   S_FETCH  | imem_req held at pc until imem_ack
//   S_DECODE | halt check, jump condition sampled from flags
//   S_EXEC   | exec_en high for non-jump opcodes
//   S_NEXT   | pc update, retire count, step_mode check
//   S_PAUSE  | single-step stop, waiting for start
//   S_HALT   | halt opcode seen, pc held, waiting for start
module instr_sequencer
  import sequencer_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step_mode,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  input  logic [3:0]      flags,
  output logic [31:0]     ir,
  output logic            exec_en,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            busy,
  output logic [31:0]     instr_count
);

  state_t          state;
  logic [4:0]      oper_type;
  logic            is_jump;
  logic            taken;
  logic            jump_taken_q;
  logic [PC_W-1:0] jump_tgt;

  assign oper_type = ir[OPER_MSB:OPER_LSB];
  assign jump_tgt  = ir[ISRC_LSB +: PC_W];
  // pc only changes outside FETCH, so the address is stable for the whole request
  assign imem_addr = pc;

  jump_resolve u_jump_resolve (
    .oper_type (oper_type),
    .flags     (flags),
    .is_jump   (is_jump),
    .taken     (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= '0;
      ir           <= '0;
      instr_count  <= '0;
      imem_req     <= 1'b0;
      exec_en      <= 1'b0;
      halted       <= 1'b0;
      busy         <= 1'b0;
      jump_taken_q <= 1'b0;
    end else begin
      exec_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc       <= '0;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (oper_type == OP_HALT) begin
            halted <= 1'b1;
            busy   <= 1'b0;
            state  <= S_HALT;
          end else begin
            // flags here are those left by the previous instruction
            jump_taken_q <= is_jump & taken;
            exec_en      <= ~is_jump;
            state        <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_NEXT;
        end
        S_NEXT: begin
          pc          <= jump_taken_q ? jump_tgt : pc + PC_W'(1);
          instr_count <= instr_count + 32'd1;
          if (step_mode) begin
            busy  <= 1'b0;
            state <= S_PAUSE;
          end else begin
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_PAUSE: begin
          if (start) begin
            imem_req <= 1'b1;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_HALT: begin
          if (start) begin
            pc       <= pc + PC_W'(1);
            halted   <= 1'b0;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        default: begin
          imem_req <= 1'b0;
          halted   <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table of single-stepped
// instructions with a retire scoreboard, plus hand-written corner sequences.
module tb_instr_sequencer;
  import sequencer_pkg::*;

  localparam int PC_W = 16;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_MOV = 5'd2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            step_mode = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ack;
  logic [3:0]      flags = 4'b0;
  logic [31:0]     ir;
  logic            exec_en;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            busy;
  logic [31:0]     instr_count;

  instr_sequencer #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .step_mode   (step_mode),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .flags       (flags),
    .ir          (ir),
    .exec_en     (exec_en),
    .pc          (pc),
    .halted      (halted),
    .busy        (busy),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // memory model with programmable wait states
  logic [31:0] mem [0:65535];
  int wait_states = 0;
  int wcnt = 0;
  assign imem_ack   = imem_req && (wcnt >= wait_states);
  assign imem_rdata = imem_ack ? mem[imem_addr] : 32'h0;
  always @(posedge clk) begin
    if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [15:0] isrc);
    return {op, 5'd1, 5'd2, 1'b1, isrc};
  endfunction

  // retire scoreboard
  typedef struct {
    int              exp_exec;
    logic [PC_W-1:0] exp_pc;
    logic [31:0]     exp_count;
  } retire_t;
  retire_t sb[$];
  logic [31:0] last_count = 0;
  int exec_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_count = 0;
      exec_seen  = 0;
    end else begin
      if (exec_en) exec_seen++;
      if (instr_count != last_count) begin
        last_count = instr_count;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_retire: got count %0d expected no retire", instr_count);
        end else begin
          retire_t r;
          r = sb.pop_front();
          check("retire_pc", 32'(pc), 32'(r.exp_pc));
          check("retire_count", instr_count, r.exp_count);
          check("retire_exec_pulses", exec_seen, r.exp_exec);
        end
        exec_seen = 0;
      end
    end
  end

  // Pulse start for one cycle and wait for the sequencer to stop again.
  task automatic run_one(input logic [PC_W-1:0] exp_addr, output int req_cyc, output int busy_cyc);
    int addr_bad;
    bit done;
    req_cyc = 0; busy_cyc = 0; addr_bad = 0; done = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (imem_req) begin
        req_cyc++;
        if (imem_addr != exp_addr) addr_bad++;
      end
      if (!busy) begin done = 1; break; end
      busy_cyc++;
      @(negedge clk);
    end
    check("run_done", 32'(done), 32'd1);
    check("fetch_addr_errors", addr_bad, 0);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [15:0] isrc;
    logic [3:0]  flg;
    int          exp_exec;
    bit          exp_taken;
  } vec_t;

  vec_t vecs [14];
  logic [PC_W-1:0] model_pc;
  logic [31:0] model_count;
  int rc, bc;
  int hits [4];
  int nhits;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;

    vecs[0]  = '{OP_ADD,      16'h0000, 4'b0000, 1, 1'b0};
    vecs[1]  = '{OP_JUMP,     16'h0010, 4'b0000, 0, 1'b1};
    vecs[2]  = '{OP_JZERO,    16'h0020, 4'b0100, 0, 1'b1};
    vecs[3]  = '{OP_JZERO,    16'h0030, 4'b0000, 0, 1'b0};
    vecs[4]  = '{OP_JCARRY,   16'h0040, 4'b0001, 0, 1'b1};
    vecs[5]  = '{OP_JNOCARRY, 16'h0050, 4'b0001, 0, 1'b0};
    vecs[6]  = '{OP_JSIGN,    16'h0060, 4'b1000, 0, 1'b1};
    vecs[7]  = '{OP_JNOSIGN,  16'h0070, 4'b1000, 0, 1'b0};
    vecs[8]  = '{OP_JOVF,     16'h0080, 4'b0010, 0, 1'b1};
    vecs[9]  = '{OP_JNOOVF,   16'h0090, 4'b0000, 0, 1'b1};
    vecs[10] = '{OP_JNOZERO,  16'h00A0, 4'b0100, 0, 1'b0};
    vecs[11] = '{OP_JNOSIGN,  16'hFFFF, 4'b0000, 0, 1'b1};
    vecs[12] = '{OP_MOV,      16'h1234, 4'b1111, 1, 1'b0};
    vecs[13] = '{OP_JNOCARRY, 16'h0005, 4'b0000, 0, 1'b1};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_exec", 32'(exec_en), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // ADD, MOV, HALT free-running: commits 4 and 8 cycles into the run,
    // i.e. exec_en seen after the 3rd and 7th edge following the start edge
    mem[0] = mk(OP_ADD, 16'h0);
    mem[1] = mk(OP_MOV, 16'h0);
    mem[2] = mk(OP_HALT, 16'h0);
    sb.push_back('{1, 16'd1, 32'd1});
    sb.push_back('{1, 16'd2, 32'd2});
    nhits = 0;
    @(negedge clk) start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start = 1'b0;
      if (exec_en && nhits < 4) begin hits[nhits] = n; nhits++; end
    end
    check("prog_exec_count", nhits, 2);
    check("prog_exec_first", hits[0], 3);
    check("prog_exec_second", hits[1], 7);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'd2);
    check("halt_count", instr_count, 32'd2);
    check("halt_busy", 32'(busy), 32'd0);

    // resume from HALT fetches halt address + 1
    step_mode = 1'b1;
    mem[3] = mk(OP_ADD, 16'h0);
    sb.push_back('{1, 16'd4, 32'd3});
    run_one(16'd3, rc, bc);
    check("resume_halted", 32'(halted), 32'd0);

    // table of single-stepped instructions from a fresh reset
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_pc = '0;
    model_count = '0;
    foreach (vecs[i]) begin
      logic [PC_W-1:0] nxt;
      mem[model_pc] = mk(vecs[i].op, vecs[i].isrc);
      flags = vecs[i].flg;
      nxt = vecs[i].exp_taken ? vecs[i].isrc[PC_W-1:0] : model_pc + PC_W'(1);
      model_count++;
      sb.push_back('{vecs[i].exp_exec, nxt, model_count});
      run_one(model_pc, rc, bc);
      check("pause_busy", 32'(busy), 32'd0);
      check("pause_halted", 32'(halted), 32'd0);
      model_pc = nxt;
    end

    // paused: no progress without start
    repeat (10) @(negedge clk);
    check("pause_hold_count", instr_count, model_count);
    check("pause_hold_req", 32'(imem_req), 32'd0);

    // 3 wait states: request held 4 cycles, 7-cycle instruction
    wait_states = 3;
    flags = 4'b0;
    mem[model_pc] = mk(OP_ADD, 16'h0);
    model_count++;
    sb.push_back('{1, model_pc + PC_W'(1), model_count});
    run_one(model_pc, rc, bc);
    check("wait_req_cycles", rc, 4);
    check("wait_latency", bc, 7);
    model_pc = model_pc + PC_W'(1);

    // reset during a long fetch wait
    wait_states = 50;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_req", 32'(imem_req), 32'd1);
    check("pre_rst_pc", 32'(pc), 32'(model_pc));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_count", instr_count, 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_states = 0;
    mem[0] = mk(OP_MOV, 16'h0);
    sb.push_back('{1, 16'd1, 32'd1});
    run_one(16'd0, rc, bc);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control unit that fetches 32-bit instructions from instruction memory, presents them to the GPR/ALU datapath on the `ir` bus, and strobes commit. It owns the program counter and resolves jumps and halt. It sits between the instruction memory and the existing combinational decode/execute datapath, replacing direct testbench writes to `IR`.

## Interface

Parameters:

- `PC_W`, 16: program counter and instruction address width.

Ports:

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; begins or resumes execution (see Operation).
- `step_mode`  in  1  1 = pause after every retired instruction.
- `imem_req`  out  1  instruction read request.
- `imem_addr`  out  PC_W  read address; equals `pc` while `imem_req` = 1.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack` = 1.
- `imem_ack`  in  1  read completes this cycle.
- `flags`  in  4  datapath flags `{sign, zero, overflow, carry}`.
- `ir`  out  32  current instruction to the datapath.
- `exec_en`  out  1  one-cycle commit strobe; the datapath writes GPR/flags on this edge.
- `pc`  out  PC_W  current program counter.
- `halted`  out  1  in HALT state.
- `busy`  out  1  not in IDLE, PAUSE or HALT.
- `instr_count`  out  32  retired-instruction counter; wraps.

## Operation

- IR fields: `oper_type` = ir[31:27], `rdst` = [26:22], `rsrc1` = [21:17], `imm_mode` = [16], `rsrc2` = [15:11], `isrc` = [15:0].
- States: IDLE, FETCH, DECODE, EXEC, NEXT, PAUSE, HALT.
- IDLE: on `start` = 1, set `pc` = 0 and go to FETCH.
- FETCH: hold `imem_req` = 1 and `imem_addr` = `pc` until `imem_ack`. On ack, latch `ir` <= `imem_rdata` and go to DECODE. There is no limit on wait states.
- DECODE: `oper_type` = OP_HALT goes to HALT. Otherwise go to EXEC. For jump opcodes, sample `flags` here; these are the flags left by the previous instruction.
- EXEC: `exec_en` = 1 for exactly one cycle for non-jump opcodes. Jumps do not assert `exec_en`. Go to NEXT.
- NEXT: if a jump is taken, `pc` <= `isrc[PC_W-1:0]`; otherwise `pc` <= `pc`+1, mod 2^PC_W. Increment `instr_count`. Then go to PAUSE if `step_mode`, else FETCH.
- Jump conditions:
  - JUMP: always.
  - JCARRY / JNOCARRY: carry = 1 / 0.
  - JSIGN / JNOSIGN: sign = 1 / 0.
  - JZERO / JNOZERO: zero = 1 / 0.
  - JOVF / JNOOVF: overflow = 1 / 0.
- PAUSE: `start` = 1 goes to FETCH.
- HALT: `halted` = 1 and `pc` is held at the halt address. `start` = 1 sets `pc` <= `pc`+1 and goes to FETCH. A halt does not increment `instr_count`.

## Timing

- Reset values: state IDLE, `pc` = 0, `ir` = 0, `instr_count` = 0. All single-bit outputs are 0.
- Reset mid-operation: return to IDLE immediately. An outstanding `imem_req` is dropped, and the memory must tolerate an abandoned request.
- With zero wait states (ack in the first FETCH cycle), one instruction takes 4 cycles: FETCH, DECODE, EXEC, NEXT. Each wait state adds 1 cycle.
- `exec_en` is registered and asserted only in EXEC. `ir` is stable from the DECODE cycle until the next ack.
- `start` is level-sensitive. Held high in PAUSE, it gives continuous stepping.
- `step_mode` is sampled only in NEXT.
- `pc` wraps from 2^PC_W−1 to 0 with no error.
- `instr_count` wraps from 0xFFFFFFFF to 0.

## Structure

- Shared package `sequencer_pkg`, containing:
  - state enum;
  - IR field bit positions;
  - opcode constants: OP_JUMP = 15, OP_JCARRY = 16, OP_JNOCARRY = 17, OP_JSIGN = 18, OP_JNOSIGN = 19, OP_JZERO = 20, OP_JNOZERO = 21, OP_JOVF = 22, OP_JNOOVF = 23, OP_HALT = 27;
  - flag bit indices.
- One sub-module, `jump_resolve`: combinational; takes `oper_type` and `flags`, returns `is_jump` and `taken`.

## Test plan

- Reset, `start` = 1, memory holds ADD, MOV, HALT, zero wait states -> `exec_en` pulses at cycles 4 and 8 after start; `halted` = 1 with `pc` = 2; `instr_count` = 2.
- Address 0 holds JUMP with `isrc` = 0x0010 -> no `exec_en`; next `imem_addr` = 0x0010; `instr_count` = 1.
- `flags` = 4'b0100 (zero) with JZERO to 0x20 -> `pc` = 0x20; repeat with `flags` = 0 -> `pc` = 1.
- 3-cycle `imem_ack` delay -> `imem_req` held high for 4 cycles with a stable address; instruction latency = 7 cycles.
- `step_mode` = 1 -> state PAUSE after each NEXT with `busy` = 0; a one-cycle `start` advances exactly one instruction.
- `rst_n` asserted during FETCH wait -> `imem_req`, `pc`, `instr_count` and `halted` all 0 immediately; restart fetches address 0.
